// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the pipelined signed MAC.
// Clamp limits are derived from the accumulator width so one package serves every instance.
package mac_pkg;

  localparam int MAX_ACC_W = 64;

  typedef logic signed [MAX_ACC_W-1:0] wide_t;

  typedef struct packed {
    logic                 ovf;
    logic [MAX_ACC_W-1:0] sum;
  } sat_res_t;

  function automatic wide_t acc_max(input int acc_w);
    wide_t one;
    one = 1;
    return (one <<< (acc_w - 1)) - one;
  endfunction

  function automatic wide_t acc_min(input int acc_w);
    wide_t one;
    one = 1;
    return -acc_max(acc_w) - one;
  endfunction

  // Both operands lie inside the acc_w range, so one guard bit above MAX_ACC_W is enough.
  function automatic sat_res_t sat_add(input wide_t acc, input wide_t p, input int acc_w);
    logic signed [MAX_ACC_W:0] w_sum;
    logic signed [MAX_ACC_W:0] w_hi;
    logic signed [MAX_ACC_W:0] w_lo;
    sat_res_t res;
    w_sum = {acc[MAX_ACC_W-1], acc} + {p[MAX_ACC_W-1], p};
    w_hi  = {1'b0, acc_max(acc_w)};
    w_lo  = {1'b1, acc_min(acc_w)};
    res.ovf = 1'b1;
    if (w_sum > w_hi) begin
      res.sum = w_hi[MAX_ACC_W-1:0];
    end else if (w_sum < w_lo) begin
      res.sum = w_lo[MAX_ACC_W-1:0];
    end else begin
      res.ovf = 1'b0;
      res.sum = w_sum[MAX_ACC_W-1:0];
    end
    return res;
  endfunction

  function automatic bit params_ok(input int data_w, input int acc_w, input int acc_len);
    return (data_w >= 1) && (acc_w >= 2 * data_w) && (acc_w <= MAX_ACC_W) && (acc_len >= 1);
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Two-stage signed DATA_W x DATA_W multiplier: operand register, then product register.
// i_clr empties both stages even while i_en holds the pipe.
module mult_pipe #(
  parameter int DATA_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_clr,
  input  logic                       i_valid,
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic                       o_valid,
  output logic signed [2*DATA_W-1:0] o_p
);

  logic                       r_v1;
  logic                       r_v2;
  logic signed [DATA_W-1:0]   r_a;
  logic signed [DATA_W-1:0]   r_b;
  logic signed [2*DATA_W-1:0] r_p;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_p  <= '0;
    end else if (i_clr) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (i_en) begin
      r_v1 <= i_valid;
      r_a  <= i_a;
      r_b  <= i_b;
      r_v2 <= r_v1;
      r_p  <= (2*DATA_W)'(r_a) * (2*DATA_W)'(r_b);
    end
  end

  assign o_valid = r_v2;
  assign o_p     = r_p;

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate: ACC_LEN saturated products per emitted sum.
// Handshake: a pair moves on in_valid && in_ready, a sum on out_valid && out_ready; a held output stalls the whole pipe.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int ACC_LEN = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] d_in_a,
  input  logic signed [DATA_W-1:0] d_in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  d_out,
  output logic                     sat
);

  if (!params_ok(DATA_W, ACC_W, ACC_LEN)) begin : g_bad_params
    $error("mac_pipe: illegal DATA_W/ACC_W/ACC_LEN combination");
  end

  localparam int                CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic                       w_adv;
  logic                       w_accept;
  logic                       w_p_valid;
  logic signed [2*DATA_W-1:0] w_p;
  logic                       w_add;
  logic                       w_last;
  sat_res_t                   w_res;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       w_unused;

  logic signed [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [ACC_W-1:0]    r_d_out;
  logic                       r_out_valid;
  logic                       r_sat;

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = rst && w_adv && !clear;
  assign w_accept = in_valid && in_ready;

  mult_pipe #(
    .DATA_W (DATA_W)
  ) u_mult (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_adv),
    .i_clr   (clear),
    .i_valid (w_accept),
    .i_a     (d_in_a),
    .i_b     (d_in_b),
    .o_valid (w_p_valid),
    .o_p     (w_p)
  );

  assign w_res    = sat_add(wide_t'(r_acc), wide_t'(w_p), ACC_W);
  assign w_sum    = w_res.sum[ACC_W-1:0];
  assign w_unused = ^w_res.sum;
  assign w_add    = w_adv && w_p_valid && !clear;
  assign w_last   = w_add && (r_cnt == CNT_LAST);

  // Accumulator restarts from zero after the last add, so the first add of a window sees acc=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_add) begin
      r_sat <= (r_cnt == '0) ? w_res.ovf : (r_sat | w_res.ovf);
      if (r_cnt == CNT_LAST) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_out     <= '0;
      r_out_valid <= 1'b0;
    end else if (w_last) begin
      r_d_out     <= w_sum;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign d_out     = r_d_out;
  assign sat       = r_sat;

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: three instances (default, 16-bit/len-3 accumulator, len-1 multiplier)
// driven by directed and random streams and checked by a window-level reference model.
module tb_mac_pipe;

  localparam int NL = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  logic [NL-1:0] clear    = '0;
  logic [NL-1:0] in_valid = '0;
  logic [NL-1:0] out_ready = '1;
  logic [NL-1:0] in_ready;
  logic [NL-1:0] out_valid;
  logic [NL-1:0] sat;
  logic [7:0]    av [NL];
  logic [7:0]    bv [NL];
  logic          ir0, ir1, ir2, ov0, ov1, ov2, st0, st1, st2;
  logic signed [31:0] dout0, dout2;
  logic signed [15:0] dout1;

  assign in_ready  = {ir2, ir1, ir0};
  assign out_valid = {ov2, ov1, ov0};
  assign sat       = {st2, st1, st0};

  mac_pipe #(.DATA_W(8), .ACC_W(32), .ACC_LEN(9)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(ir0),
    .d_in_a(av[0]), .d_in_b(bv[0]), .out_valid(ov0), .out_ready(out_ready[0]),
    .d_out(dout0), .sat(st0));

  mac_pipe #(.DATA_W(8), .ACC_W(16), .ACC_LEN(3)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(ir1),
    .d_in_a(av[1]), .d_in_b(bv[1]), .out_valid(ov1), .out_ready(out_ready[1]),
    .d_out(dout1), .sat(st1));

  mac_pipe #(.DATA_W(8), .ACC_W(32), .ACC_LEN(1)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(ir2),
    .d_in_a(av[2]), .d_in_b(bv[2]), .out_valid(ov2), .out_ready(out_ready[2]),
    .d_out(dout2), .sat(st2));

  int checks = 0;
  int errors = 0;

  function automatic int lane_len(input int l);
    case (l)
      0:       return 9;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int lane_accw(input int l);
    return (l == 1) ? 16 : 32;
  endfunction

  function automatic longint dout_of(input int l);
    case (l)
      0:       return longint'(dout0);
      1:       return longint'(dout1);
      default: return longint'(dout2);
    endcase
  endfunction

  task automatic chk(input string name, input int l, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d: got %0d, expected %0d", name, l, act, exp);
    end
  endtask

  // scoreboard: {sat, sum} per completed window
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q2[$];
  longint      win [NL][16];
  int          win_n [NL];
  int          last_acc [NL];
  bit [NL-1:0] clr_since;

  function automatic int q_size(input int l);
    case (l)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [32:0] q_front(input int l);
    case (l)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic void q_pop(input int l);
    case (l)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endfunction

  function automatic void q_push(input int l, input logic [32:0] e);
    case (l)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endfunction

  // Reference: collect a window of products, then fold it with a clamped running sum.
  function automatic void model_accept(input int l, input logic signed [7:0] a, input logic signed [7:0] b);
    longint s, hi, lo;
    bit any;
    win[l][win_n[l]] = longint'(a) * longint'(b);
    win_n[l]++;
    if (win_n[l] == lane_len(l)) begin
      hi  = (longint'(1) << (lane_accw(l) - 1)) - 1;
      lo  = -hi - 1;
      s   = 0;
      any = 1'b0;
      for (int i = 0; i < win_n[l]; i++) begin
        s = s + win[l][i];
        if (s > hi) begin s = hi; any = 1'b1; end
        else if (s < lo) begin s = lo; any = 1'b1; end
      end
      q_push(l, {any, s[31:0]});
      win_n[l] = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    for (int l = 0; l < NL; l++) win_n[l] = 0;
    clr_since = '0;
  endfunction

  // backpressure source
  bit [NL-1:0] bp_rand  = '0;
  bit [NL-1:0] or_force = '1;
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < NL; l++)
      out_ready[l] = bp_rand[l] ? ($urandom_range(0, 3) != 0) : or_force[l];
  end

  // monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int l = 0; l < NL; l++) begin
        logic [32:0] e;
        if (out_valid[l]) begin
          if (q_size(l) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output lane %0d: got d_out %0d, expected no output", l, dout_of(l));
          end else begin
            e = q_front(l);
            chk("d_out", l, dout_of(l), longint'($signed(e[31:0])));
            chk("sat", l, longint'(sat[l]), longint'(e[32] && !clr_since[l]));
            if (out_ready[l]) begin
              q_pop(l);
              clr_since[l] = 1'b0;
            end else if (clear[l]) begin
              clr_since[l] = 1'b1;
            end
          end
        end
        chk("in_ready", l, longint'(in_ready[l]),
            longint'(!(out_valid[l] && !out_ready[l]) && !clear[l]));
      end
    end
  end

  // driver tasks (each returns 1 time unit after a rising edge)
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int l, input logic signed [7:0] a, input logic signed [7:0] b);
    int n;
    n = 0;
    in_valid[l] = 1'b1;
    av[l] = a;
    bv[l] = b;
    @(negedge clk);
    while (!in_ready[l] && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[l]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout lane %0d: got in_ready 0, expected 1 within 300 cycles", l);
    end else begin
      model_accept(l, a, b);
      last_acc[l] = cyc;
    end
    sync();
    in_valid[l] = 1'b0;
  endtask

  task automatic wait_ov(input int l);
    int n;
    n = 0;
    while (!out_valid[l] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid[l]) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout lane %0d: got out_valid 0, expected 1", l);
    end
  endtask

  task automatic check_latency(input int l);
    wait_ov(l);
    chk("latency", l, longint'(cyc - last_acc[l]), 3);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 0, longint'(q_size(0) + q_size(1) + q_size(2)), 0);
    sync();
  endtask

  task automatic pulse_clear(input int l);
    clear[l] = 1'b1;
    model_reset_lane(l);
    sync();
    clear[l] = 1'b0;
  endtask

  function automatic void model_reset_lane(input int l);
    win_n[l] = 0;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) begin
      chk("rst_out_valid", l, longint'(out_valid[l]), 0);
      chk("rst_in_ready", l, longint'(in_ready[l]), 0);
      chk("rst_d_out", l, dout_of(l), 0);
      chk("rst_sat", l, longint'(sat[l]), 0);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic signed [7:0] rand_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return -8'sd128;
    if (r == 1) return 8'sd127;
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic random_stream(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      send(l, rand_op(), rand_op());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
  endtask

  logic signed [7:0] sw_a [7];
  logic signed [7:0] sw_b [7];

  initial begin
    for (int l = 0; l < NL; l++) begin
      av[l] = '0;
      bv[l] = '0;
      win_n[l] = 0;
      last_acc[l] = 0;
    end
    clr_since = '0;
    do_reset();

    // signed extremes, back-to-back, one pulse after 3 cycles
    for (int i = 0; i < 9; i++) send(0, -8'sd128, -8'sd128);
    check_latency(0);
    @(negedge clk);
    chk("single_pulse", 0, longint'(out_valid[0]), 0);
    sync();
    wait_drain();

    // 16-bit accumulator: saturation, then sat clears on the next window
    for (int i = 0; i < 3; i++) send(1, 8'sd127, 8'sd127);
    for (int i = 0; i < 3; i++) send(1, 8'sd1, 8'sd1);
    wait_drain();
    or_force[1] = 1'b0;
    for (int i = 0; i < 3; i++) send(1, 8'sd127, 8'sd127);
    wait_ov(1);
    sync();
    pulse_clear(1);
    @(negedge clk);
    chk("sat_after_clear", 1, longint'(sat[1]), 0);
    chk("pending_after_clear", 1, dout_of(1), 32767);
    sync();
    or_force[1] = 1'b1;
    wait_drain();

    // two windows with a 5-cycle stall after the first output
    or_force[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 18; i++) send(0, rand_op(), rand_op());
      end
      begin
        wait_ov(0);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 0, longint'(in_ready[0]), 0);
        end
        sync();
        or_force[0] = 1'b1;
      end
    join
    wait_drain();

    // pipelined multiplier sweep
    sw_a = '{-8'sd128, 8'sd0, -8'sd128, 8'sd127, -8'sd1, 8'sd5, 8'sd100};
    sw_b = '{8'sd127, -8'sd1, -8'sd128, 8'sd127, 8'sd1, -8'sd5, -8'sd3};
    for (int i = 0; i < 7; i++) send(2, sw_a[i], sw_b[i]);
    wait_drain();
    send(2, -8'sd128, 8'sd127);
    check_latency(2);
    sync();
    wait_drain();

    // clear keeps a pending sum and discards a partial window
    or_force[0] = 1'b0;
    for (int i = 0; i < 9; i++) send(0, 8'sd5, -8'sd7);
    wait_ov(0);
    sync();
    pulse_clear(0);
    @(negedge clk);
    chk("pending_valid_kept", 0, longint'(out_valid[0]), 1);
    chk("pending_data_kept", 0, dout_of(0), -315);
    sync();
    or_force[0] = 1'b1;
    wait_drain();
    for (int i = 0; i < 4; i++) send(0, 8'sd9, 8'sd9);
    idle(3);
    pulse_clear(0);
    for (int i = 0; i < 9; i++) send(0, 8'sd2, 8'sd3);
    wait_drain();

    // asynchronous reset mid-window and mid-stall
    for (int i = 0; i < 4; i++) send(0, 8'sd1, 8'sd2);
    do_reset();
    or_force[0] = 1'b0;
    for (int i = 0; i < 9; i++) send(0, 8'sd3, 8'sd3);
    wait_ov(0);
    sync();
    do_reset();
    or_force[0] = 1'b1;
    for (int i = 0; i < 9; i++) send(0, 8'sd1, 8'sd1);
    wait_drain();

    // random operands, gaps and backpressure on all lanes at once
    bp_rand = '1;
    fork
      random_stream(0, 45);
      random_stream(1, 30);
      random_stream(2, 40);
    join
    bp_rand = '0;
    or_force = '1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution datapath; next generation of the single-cycle 8x8 signed multiplier.
- Takes a stream of signed operand pairs over a valid/ready handshake and multiplies them with a fixed 2-stage pipeline.
- Accumulates ACC_LEN products (e.g. one 3x3 kernel window) with saturation and emits one sign-extended sum per window over a valid/ready output.

Parameters:
- DATA_W, 8, signed operand width.
- ACC_W, 32, signed accumulator and output width; must satisfy ACC_W >= 2*DATA_W.
- ACC_LEN, 9, products per output sum; must be >= 1. ACC_LEN=1 gives a pipelined multiplier.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of the in-flight window.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- d_in_a  in  DATA_W  signed operand A.
- d_in_b  in  DATA_W  signed operand B.
- out_valid  out  1  d_out holds a completed sum.
- out_ready  in  1  downstream accepts d_out.
- d_out  out  ACC_W  signed saturated sum.
- sat  out  1  sticky flag: some accumulation in the current or last emitted window saturated.

Behaviour:
- Reset (rst=0, async):
  - All valid bits, the counter, the accumulator, d_out and sat go to 0.
  - out_valid=0, in_ready=0 while reset is asserted.
  - Reset mid-window discards everything; there is no partial output.
- Global advance enable: adv = !(out_valid && !out_ready).
  - in_ready = adv && !clear.
  - Accept when in_valid && in_ready.
  - When adv=0, every pipeline register holds (full stall).
- Pipeline stages, all gated by adv:
  - S1: register the operands and v1 = accept.
  - S2: p = signed(a)*signed(b), full 2*DATA_W bits; register with v2 = v1.
  - S3: sign-extend p to ACC_W, then saturating add into acc: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat on clamp. Only when v2=1.
- Window counter cnt, 0..ACC_LEN-1, advances on each S3 add:
  - If cnt == ACC_LEN-1: load d_out with the clamped sum, set out_valid=1, reset acc to 0 and cnt to 0.
  - Otherwise: acc takes the sum and cnt increments.
  - The first add of a window uses acc=0. Bubbles (v2=0) leave acc and cnt unchanged.
- Latency: out_valid rises 3 cycles after the accept of the window's last pair, assuming no stall. Sustained throughput is 1 pair per cycle.
- Output handshake:
  - out_valid falls on the out_valid && out_ready edge unless a new sum loads on that same edge, in which case it stays 1 with the new data.
  - d_out is stable while out_valid=1 && out_ready=0.
- sat:
  - Cleared when the first add of a new window occurs.
  - Otherwise sticky until reset or clear.
- clear=1 (synchronous):
  - Zeroes v1, v2, acc, cnt and sat; the input is not accepted that cycle.
  - out_valid and d_out are unaffected (an already-completed sum is still delivered).
  - If clear and a final S3 add coincide, clear wins and no sum is loaded.
- Signed extremes: (-2^(DATA_W-1))^2 is positive and representable in 2*DATA_W bits; no special casing.

Decomposition:
- Package mac_pkg:
  - Localparams for ACC_MAX and ACC_MIN.
  - Function sat_add(acc, p) returning the clamped sum plus an overflow bit.
  - Parameter legality checks.
- Sub-module mult_pipe (2-stage signed DATA_W x DATA_W multiplier with valid and enable): covers S1 and S2.
- Top: S3, counter, output register, handshake.

Test Plan:
- Defaults, nine pairs of (-128,-128) back-to-back, out_ready=1 -> single out_valid pulse 3 cycles after the 9th accept; d_out=147456, sat=0.
- ACC_W=16, ACC_LEN=3, three pairs of (127,127) -> d_out=32767, sat=1. The next window of (1,1)x3 -> d_out=3, sat=0.
- Defaults, two back-to-back windows, out_ready=0 held 5 cycles after the first out_valid -> in_ready=0 during the stall, d_out holds. The second sum is correct after release and no pair is lost.
- ACC_LEN=1, a/b sweep including (-128,127)=-16256 and (0,-1)=0 -> one output per input, 3-cycle latency.
- Clear asserted after 4 of 9 pairs, then 9 pairs of (2,3) -> first emitted d_out=54 (partial discarded); a previously pending out_valid is preserved.
- rst pulsed low asynchronously mid-window and mid-stall -> all outputs 0 immediately. After release, 9 pairs of (1,1) -> d_out=9.
